// File: rtl/decode_immediate_sequencer_pkg.sv
// Shared type codes, RV32I opcode constants and the queued entry layout
// for the decode/immediate sequencer.
package decode_immediate_sequencer_pkg;

    // Instruction format classes understood by the immediate generator.
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instr_type_e;

    // RV32I major opcodes (instruction[6:0]).
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One queued, fully decoded instruction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        instr_type_e itype;
        logic [31:0] immediate;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/decode_immediate_sequencer_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for a given
// instruction format. Purely combinational. The opcode field carries no
// immediate bits, so only instruction[31:7] is taken.
module Immediate_Generator
    import decode_immediate_sequencer_pkg::*;
(
    input  logic [31:7] instruction,
    input  logic [2:0]  instruction_type,
    output logic [31:0] immediate
);

    // Scatter/gather the immediate fields for each format.
    always_comb begin
        immediate = '0;
        case (instr_type_e'(instruction_type))
            I_TYPE: immediate = {{20{instruction[31]}}, instruction[31:20]};
            S_TYPE: immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            B_TYPE: immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                                 instruction[30:25], instruction[11:8], 1'b0};
            U_TYPE: immediate = {instruction[31:12], 12'b0};
            J_TYPE: immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                 instruction[20], instruction[30:21], 1'b0};
            default: immediate = '0;
        endcase
    end

endmodule

// File: rtl/decode_immediate_sequencer.sv
// Decode/immediate sequencer: classifies each accepted instruction, runs
// it through the immediate generator and queues the decoded result in a
// small FIFO with valid/ready on both sides and a synchronous flush.
module decode_immediate_sequencer
    import decode_immediate_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instruction,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic [31:0]      out_pc,
    output logic [2:0]       out_type,
    output logic [31:0]      out_immediate,
    output logic             out_illegal,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    entry_t             mem [DEPTH];
    entry_t             last_q;
    entry_t             head;
    entry_t             new_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    instr_type_e        dec_type;
    logic               dec_illegal;
    logic [31:0]        gen_imm;
    logic               enq;
    logic               deq;

    // Opcode classification; unknown opcodes fall back to R_TYPE and are flagged.
    always_comb begin
        dec_type    = R_TYPE;
        dec_illegal = 1'b0;
        case (in_instruction[6:0])
            OPC_LUI, OPC_AUIPC:                      dec_type = U_TYPE;
            OPC_JAL:                                 dec_type = J_TYPE;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_SYSTEM, OPC_FENCE:                   dec_type = I_TYPE;
            OPC_STORE:                               dec_type = S_TYPE;
            OPC_BRANCH:                              dec_type = B_TYPE;
            OPC_OP:                                  dec_type = R_TYPE;
            default: begin
                dec_type    = R_TYPE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    Immediate_Generator u_imm_gen (
        .instruction      (in_instruction[31:7]),
        .instruction_type (dec_type),
        .immediate        (gen_imm)
    );

    // Build the entry to enqueue; R_TYPE (including illegal) carries no immediate.
    always_comb begin
        new_entry             = '0;
        new_entry.pc          = in_pc;
        new_entry.instruction = in_instruction;
        new_entry.itype       = dec_type;
        new_entry.immediate   = (dec_type == R_TYPE) ? '0 : gen_imm;
        new_entry.illegal     = dec_illegal;
    end

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign occupancy = count;
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready & ~flush;

    // FIFO state: flush outranks enqueue/dequeue; last_q keeps the most recently
    // dequeued entry so outputs hold it while the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head selection: stored entry at rd_ptr, or the last dequeued one when empty.
    always_comb begin
        head = (count == '0) ? last_q : mem[rd_ptr];
    end

    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;
    assign out_type        = head.itype;
    assign out_immediate   = head.immediate;
    assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_decode_immediate_sequencer.sv
// Directed self-checking bench for decode_immediate_sequencer (DEPTH = 2).
module tb_decode_immediate_sequencer;
    import decode_immediate_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  out_type;
    logic [31:0] out_immediate;
    logic        out_illegal;
    logic [1:0]  occupancy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    decode_immediate_sequencer #(.DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_type        (out_type),
        .out_immediate   (out_immediate),
        .out_illegal     (out_illegal),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into an empty queue, check the head, then drain it and
    // check the outputs hold the drained entry.
    task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] exp_type, input logic [31:0] exp_imm,
                          input logic [31:0] exp_ill);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
        out_ready      = 1'b0;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_type"}, 32'(out_type), exp_type);
        chk({tag, "_imm"}, out_immediate, exp_imm);
        chk({tag, "_ill"}, 32'(out_illegal), exp_ill);
        chk({tag, "_pc"}, out_pc, pc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_empty_occ"}, 32'(occupancy), 32'd0);
        chk({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold_instr"}, out_instruction, instr);
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc          = '0;
        out_ready      = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_instr", out_instruction, 32'd0);
        chk("rst_imm", out_immediate, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,-1 then sw, held (out_ready = 0)
        in_valid = 1'b1; in_instruction = 32'hFFF00093; in_pc = 32'h100;
        step();
        chk("addi_occ", 32'(occupancy), 32'd1);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_type", 32'(out_type), 32'(I_TYPE));
        chk("addi_imm", out_immediate, 32'hFFFFFFFF);
        chk("addi_ill", 32'(out_illegal), 32'd0);
        in_instruction = 32'h0020A423; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        chk("two_occ", 32'(occupancy), 32'd2);
        chk("two_ready", 32'(in_ready), 32'd0);

        // asynchronous reset mid-stream with two entries held
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        step();

        single("sw",   32'h0020A423, 32'h110, 32'(S_TYPE), 32'h00000008, 32'd0);
        single("beq",  32'hFE000EE3, 32'h114, 32'(B_TYPE), 32'hFFFFFFFC, 32'd0);
        single("lui",  32'h123452B7, 32'h118, 32'(U_TYPE), 32'h12345000, 32'd0);
        single("jal",  32'h008000EF, 32'h11C, 32'(J_TYPE), 32'h00000008, 32'd0);
        single("ill",  32'h0000007F, 32'h120, 32'(R_TYPE), 32'h00000000, 32'd1);
        single("add",  32'h002081B3, 32'h124, 32'(R_TYPE), 32'h00000000, 32'd0);

        // backpressure: three words offered, only two fit
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'hFFF00093; in_pc = 32'h200;
        step();
        in_instruction = 32'h0020A423; in_pc = 32'h204;
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_instruction = 32'hFE000EE3; in_pc = 32'h208;
        step();
        chk("bp_full_occ", 32'(occupancy), 32'd2);
        chk("bp_head_stable", out_pc, 32'h200);
        chk("bp_head_instr", out_instruction, 32'hFFF00093);
        out_ready = 1'b1;
        step();
        chk("bp_drain1_occ", 32'(occupancy), 32'd1);
        chk("bp_drain1_pc", out_pc, 32'h204);
        step();
        in_valid = 1'b0;
        chk("bp_simul_occ", 32'(occupancy), 32'd1);
        chk("bp_drain2_pc", out_pc, 32'h208);
        chk("bp_drain2_type", 32'(out_type), 32'(B_TYPE));
        step();
        out_ready = 1'b0;
        chk("bp_empty_occ", 32'(occupancy), 32'd0);
        chk("bp_empty_hold", out_pc, 32'h208);

        // flush while full, with new input and consumer ready
        in_valid = 1'b1; in_instruction = 32'h123452B7; in_pc = 32'h300;
        step();
        in_instruction = 32'h008000EF; in_pc = 32'h304;
        step();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        flush = 1'b1; out_ready = 1'b1;
        in_instruction = 32'h002081B3; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        step();
        chk("fl_nothing_occ", 32'(occupancy), 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'hFFF00093; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        chk("fl_after_pc", out_pc, 32'h400);
        chk("fl_after_occ", 32'(occupancy), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
